// File: rtl/mul_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined FP multiplier among NREQ requesters.
// Results are captured into a response FIFO and returned in issue order, tagged with the requester ID.
module mul_pipe_sched #(
    parameter  int EXPO_W = 8,
    parameter  int MANT_W = 23,
    parameter  int NREQ   = 4,
    parameter  int LAT    = 2,
    parameter  int FIFO_D = 4,
    localparam int W      = 1 + EXPO_W + MANT_W,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              mul_vld_o,
    output logic [W-1:0]      mul_a_o,
    output logic [W-1:0]      mul_b_o,
    input  logic [W-1:0]      mul_res_i,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam int            CW    = $clog2(FIFO_D + 1);
    localparam int            PW    = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_D);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           grant_found;
    logic           can_issue;
    logic           issue;

    logic [LAT-1:0] sr_vld;
    logic [IDW-1:0] sr_id [LAT];
    logic [CW-1:0]  inflight_cnt;

    logic [W-1:0]   mem_data [FIFO_D];
    logic [IDW-1:0] mem_id   [FIFO_D];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_cnt;
    logic           push;
    logic           pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(sr_vld[i]);
        end
    end

    // Credits come only from registered state, so a pop frees its slot one cycle later.
    assign can_issue = rst_n &&
                       (({1'b0, fifo_cnt} + {1'b0, inflight_cnt}) < {1'b0, DEPTH});

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant       = IDW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (can_issue && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign issue     = can_issue && grant_found;
    assign mul_vld_o = issue;
    assign mul_a_o   = issue ? req_a[int'(grant)*W +: W] : '0;
    assign mul_b_o   = issue ? req_b[int'(grant)*W +: W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end
    end

    // Stage LAT-1 lines up with the multiplier result for the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                sr_id[i] <= '0;
            end
        end else begin
            sr_vld[0] <= issue;
            sr_id[0]  <= grant;
            for (int i = 1; i < LAT; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_id[i]  <= sr_id[i-1];
            end
        end
    end

    assign push = sr_vld[LAT-1];
    assign pop  = (fifo_cnt != '0) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                mem_data[i] <= '0;
                mem_id[i]   <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= mul_res_i;
                mem_id[wr_ptr]   <= sr_id[LAT-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
    assign busy      = (inflight_cnt != '0) || (fifo_cnt != '0);

    fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(push && (fifo_cnt == DEPTH)));

endmodule

// File: tb/tb_mul_pipe_sched.sv
// Directed self-checking bench for mul_pipe_sched with a two-stage FP multiplier stub.
// Requester i always offers A_i * 2.0, so each id maps to one known product.
module tb_mul_pipe_sched;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         mul_vld_o;
    logic [31:0]  mul_a_o;
    logic [31:0]  mul_b_o;
    logic [31:0]  mul_res_i;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;

    logic [31:0]  m1_res = '0;
    logic [31:0]  m2_res = '0;
    logic [31:0]  exp_data [4];
    int           checks = 0;
    int           errors = 0;

    mul_pipe_sched #(
        .EXPO_W(8), .MANT_W(23), .NREQ(4), .LAT(2), .FIFO_D(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_vld_o (mul_vld_o),
        .mul_a_o   (mul_a_o),
        .mul_b_o   (mul_b_o),
        .mul_res_i (mul_res_i),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-precision multiply for normal operands, truncating; enough for exact small products.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    always @(posedge clk) begin
        m1_res <= mul_vld_o ? fp_mul(mul_a_o, mul_b_o) : 32'hDEAD_BEEF;
        m2_res <= m1_res;
    end
    assign mul_res_i = m2_res;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        rsp_ready = r;
        #2;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_a     = {32'h4000_0000, 32'h4080_0000, 32'h3F80_0000, 32'h4040_0000};
        req_b     = {4{32'h4000_0000}};
        exp_data[0] = 32'h40C0_0000;
        exp_data[1] = 32'h4000_0000;
        exp_data[2] = 32'h4100_0000;
        exp_data[3] = 32'h4080_0000;

        // Reset state, with all requesters already asking
        #3;
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_vld", 32'(mul_vld_o), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rsp_data", rsp_data, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        rst_n     = 1'b1;

        // Single request: 3.0 * 2.0 from req0
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t1_ready", 32'(req_ready), 32'h1);
        checkOutput("t1_vld", 32'(mul_vld_o), 32'h1);
        checkOutput("t1_mul_a", mul_a_o, 32'h4040_0000);
        checkOutput("t1_mul_b", mul_b_o, 32'h4000_0000);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t1_vld_idle", 32'(mul_vld_o), 32'h0);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        checkOutput("t1_rsp_early1", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t1_rsp_early2", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t1_rsp_data", rsp_data, 32'h40C0_0000);
        checkOutput("t1_rsp_id", 32'(rsp_id), 32'h0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t1_rsp_gone", 32'(rsp_valid), 32'h0);
        checkOutput("t1_busy_end", 32'(busy), 32'h0);

        // All requesters streaming with the consumer always ready
        doReset();
        for (int k = 0; k < 11; k++) begin
            applyStimulus((k < 8) ? 4'hF : 4'h0, 1'b1);
            if (k < 8) begin
                checkOutput("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
                checkOutput("t2_vld", 32'(mul_vld_o), 32'h1);
            end
            if (k >= 3) begin
                checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
                checkOutput("t2_rsp_id", 32'(rsp_id), 32'((k - 3) % 4));
                checkOutput("t2_rsp_data", rsp_data, exp_data[(k - 3) % 4]);
            end
        end
        applyStimulus(4'h0, 1'b1);
        checkOutput("t2_drained", 32'(rsp_valid), 32'h0);
        checkOutput("t2_busy", 32'(busy), 32'h0);

        // Consumer stalled: credits run out after exactly four handshakes
        doReset();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(4'hF, 1'b0);
            checkOutput("t3_ready", 32'(req_ready), (k < 4) ? 32'(1 << k) : 32'h0);
            checkOutput("t3_vld", 32'(mul_vld_o), (k < 4) ? 32'h1 : 32'h0);
        end
        checkOutput("t3_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t3_busy", 32'(busy), 32'h1);
        checkOutput("t3_head_id", 32'(rsp_id), 32'h0);
        checkOutput("t3_head_data", rsp_data, exp_data[0]);
        applyStimulus(4'hF, 1'b1);
        checkOutput("t3_no_bypass", 32'(req_ready), 32'h0);
        applyStimulus(4'hF, 1'b0);
        checkOutput("t3_one_more", 32'(req_ready), 32'h1);
        checkOutput("t3_head_after_pop", 32'(rsp_id), 32'h1);
        applyStimulus(4'hF, 1'b0);
        checkOutput("t3_full_ready", 32'(req_ready), 32'h0);
        checkOutput("t3_full_vld", 32'(mul_vld_o), 32'h0);

        // Pop and push together at count 3, then drain to confirm order and count
        applyStimulus(4'h0, 1'b1);
        checkOutput("t6_ready", 32'(req_ready), 32'h0);
        checkOutput("t6_id_a", 32'(rsp_id), 32'h1);
        checkOutput("t6_data_a", rsp_data, exp_data[1]);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t6_id_b", 32'(rsp_id), 32'h2);
        checkOutput("t6_data_b", rsp_data, exp_data[2]);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t6_id_c", 32'(rsp_id), 32'h3);
        checkOutput("t6_data_c", rsp_data, exp_data[3]);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t6_valid_d", 32'(rsp_valid), 32'h1);
        checkOutput("t6_id_d", 32'(rsp_id), 32'h0);
        checkOutput("t6_data_d", rsp_data, exp_data[0]);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t6_empty", 32'(rsp_valid), 32'h0);
        checkOutput("t6_busy", 32'(busy), 32'h0);

        // Reset with two operations in flight and one buffered
        doReset();
        applyStimulus(4'hF, 1'b0);
        checkOutput("t5_ready0", 32'(req_ready), 32'h1);
        applyStimulus(4'hF, 1'b0);
        checkOutput("t5_ready1", 32'(req_ready), 32'h2);
        applyStimulus(4'hF, 1'b0);
        checkOutput("t5_ready2", 32'(req_ready), 32'h4);
        applyStimulus(4'hF, 1'b0);
        checkOutput("t5_pre_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t5_pre_busy", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(rsp_valid), 32'h0);
        checkOutput("t5_rst_busy", 32'(busy), 32'h0);
        checkOutput("t5_rst_vld", 32'(mul_vld_o), 32'h0);
        checkOutput("t5_rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        rst_n     = 1'b1;
        applyStimulus(4'hF, 1'b1);
        checkOutput("t5_first_grant", 32'(req_ready), 32'h1);
        checkOutput("t5_first_a", mul_a_o, 32'h4040_0000);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t5_no_stale1", 32'(rsp_valid), 32'h0);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t5_no_stale2", 32'(rsp_valid), 32'h0);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t5_rsp_id", 32'(rsp_id), 32'h0);
        checkOutput("t5_rsp_data", rsp_data, exp_data[0]);
        applyStimulus(4'h0, 1'b1);
        checkOutput("t5_empty", 32'(rsp_valid), 32'h0);

        // Only req2 and req3 active, pointer starting at 0
        doReset();
        applyStimulus(4'b1100, 1'b1);
        checkOutput("t4_grant_a", 32'(req_ready), 32'h4);
        applyStimulus(4'b1100, 1'b1);
        checkOutput("t4_grant_b", 32'(req_ready), 32'h8);
        applyStimulus(4'b1100, 1'b1);
        checkOutput("t4_grant_c", 32'(req_ready), 32'h4);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t4_rsp_id_a", 32'(rsp_id), 32'h2);
        checkOutput("t4_rsp_data_a", rsp_data, exp_data[2]);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t4_rsp_id_b", 32'(rsp_id), 32'h3);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t4_rsp_id_c", 32'(rsp_id), 32'h2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t4_empty", 32'(rsp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
